csa_final_adder: RTL



---
 rtl/csa_final_adder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/csa_final_adder.sv
// Segmented carry-propagate adder resolving a carry-save sum/carry pair, one SEG-bit segment per stage.
// Optional `CSA_FA_ZERO_FLAG_EN adds a registered out_zero flag.
module csa_final_adder #(
    parameter int unsigned W   = 17,
    parameter int unsigned SEG = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sum,
    input  logic [W-1:0] in_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_result
`ifdef CSA_FA_ZERO_FLAG_EN
    ,
    output logic         out_zero
`endif
);

    localparam int unsigned NSTG = (W + SEG - 1) / SEG;
    localparam int unsigned WP   = NSTG * SEG;
    localparam int unsigned WR   = W + 1;

    // Operands are zero-padded to NSTG*SEG so every stage adds a full SEG-bit slice;
    // when the top segment is narrow its carry-out lands in result bit W.
    logic [WP-1:0] a_q [NSTG];
    logic [WP-1:0] b_q [NSTG];
    logic [WP-1:0] r_q [NSTG];
    logic [NSTG-1:0] vld_q;
    logic [NSTG-1:0] cy_q;

    logic [WP-1:0] pa [NSTG];
    logic [WP-1:0] pb [NSTG];
    logic [WP-1:0] pr [NSTG];
    logic [WP-1:0] nr [NSTG];
    logic [SEG:0]  seg [NSTG];
    logic [NSTG-1:0] pv;
    logic [NSTG-1:0] pc;
    logic [NSTG:0]   rdy;

`ifdef CSA_FA_ZERO_FLAG_EN
    logic [NSTG-1:0] z_q;
    logic [NSTG-1:0] pz;
    logic [NSTG-1:0] nz;
`endif

    always_comb begin
        rdy[NSTG] = out_ready;
        for (int unsigned i = NSTG; i > 0; i--) begin
            rdy[i-1] = !vld_q[i-1] || rdy[i];
        end

        pa[0] = WP'(in_sum);
        pb[0] = WP'(in_carry);
        pr[0] = '0;
        pv[0] = in_valid;
        pc[0] = 1'b0;
`ifdef CSA_FA_ZERO_FLAG_EN
        pz[0] = 1'b1;
`endif
        for (int unsigned k = 1; k < NSTG; k++) begin
            pa[k] = a_q[k-1];
            pb[k] = b_q[k-1];
            pr[k] = r_q[k-1];
            pv[k] = vld_q[k-1];
            pc[k] = cy_q[k-1];
`ifdef CSA_FA_ZERO_FLAG_EN
            pz[k] = z_q[k-1];
`endif
        end

        for (int unsigned k = 0; k < NSTG; k++) begin
            seg[k] = {1'b0, pa[k][k*SEG +: SEG]} + {1'b0, pb[k][k*SEG +: SEG]}
                   + {{SEG{1'b0}}, pc[k]};
            nr[k] = pr[k];
            nr[k][k*SEG +: SEG] = seg[k][SEG-1:0];
`ifdef CSA_FA_ZERO_FLAG_EN
            nz[k] = pz[k] && (seg[k][SEG-1:0] == '0);
            // The top carry-out is a result bit, unlike the inter-stage carries
            if (k == NSTG - 1) nz[k] = nz[k] && !seg[k][SEG];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
`ifdef CSA_FA_ZERO_FLAG_EN
            z_q   <= '0;
`endif
            for (int unsigned k = 0; k < NSTG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= pv[k];
                    if (pv[k]) begin
                        a_q[k]  <= pa[k];
                        b_q[k]  <= pb[k];
                        r_q[k]  <= nr[k];
                        cy_q[k] <= seg[k][SEG];
`ifdef CSA_FA_ZERO_FLAG_EN
                        z_q[k]  <= nz[k];
`endif
                    end
                end
            end
        end
    end

    assign in_ready   = rdy[0];
    assign out_valid  = vld_q[NSTG-1];
    assign out_result = WR'({cy_q[NSTG-1], r_q[NSTG-1]});
`ifdef CSA_FA_ZERO_FLAG_EN
    assign out_zero   = z_q[NSTG-1];
`endif

endmodule
